bcd2bin: RTL and testbench
==========================

Name: bcd2bin

Overview:
Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3). It performs the inverse of the existing binary-to-BCD converter.
It converts NDIG packed BCD digits, such as digits entered on a keypad/switch UI, into a binary operand for arithmetic blocks like the difference engine.
It uses the same start/ready/done_tick handshake as the other iterative blocks in the design.

Parameters:
NDIG, 6, number of BCD digits on the input.
BIN_W, 20, binary result width. Must satisfy 2^BIN_W > 10^NDIG-1; the default covers 999999.

Ports:
clk  in  1  clock, rising-edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  request a conversion; sampled only in idle.
bcd  in  4*NDIG  packed digits; bits [3:0] = dig0 (ones), [4*NDIG-1:4*NDIG-4] = most significant digit.
ready  out  1  high in idle.
done_tick  out  1  one-cycle pulse when bin is valid.
bin  out  BIN_W  conversion result.
err  out  1  invalid-digit flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state = idle, bcd_reg = 0, bin_reg = 0, cnt = 0, err = 0.
  - Outputs: ready = 1, done_tick = 0, bin = 0.
- FSM states: idle, op, done.
  - idle:
    - ready = 1.
    - If start = 1: load bcd_reg <= bcd, bin_reg <= 0, cnt <= BIN_W-1, go to op.
    - If start = 0: hold all registers.
  - op (ready = 0), one iteration per cycle:
    - Shift {bcd_reg, bin_reg} right by 1; the LSB of bcd_reg enters the MSB of bin_reg.
    - Then, for each 4-bit digit of the shifted bcd_reg: if the digit is >= 8, subtract 3, otherwise leave it unchanged.
    - All of this completes in one clock.
    - If cnt = 0, go to done; otherwise cnt <= cnt-1.
    - Exactly BIN_W iterations are performed.
  - done:
    - done_tick = 1 for exactly this cycle, ready = 0.
    - Next state is idle.
- Latency:
  - If start is sampled at edge k, done_tick is high in the cycle following edge k+BIN_W, i.e. BIN_W+1 cycles after the start edge.
  - Default latency is 21 cycles.
- bin = bin_reg, registered.
  - Valid from the done cycle onward.
  - Held stable through idle until the next accepted start.
  - During op, bin shows intermediate values and must not be consumed.
- Handshake rules:
  - start in op or done is ignored and not queued.
  - start may be asserted in the same cycle done_tick is high; it is ignored. The block becomes ready the following cycle.
  - A start held high continuously restarts the conversion on every idle cycle, giving back-to-back conversions every BIN_W+2 cycles.
  - bcd is sampled only at start acceptance; later changes to bcd have no effect on the conversion in progress.
- Width: the counter is clog2(BIN_W) bits. Arithmetic is unsigned. No overflow can occur for valid BCD.

Optional Feature:
Macro BCD2BIN_CHECK_EN.
- Defined:
  - On start acceptance, every input digit is checked.
  - If any digit is > 9: skip op, go straight to done, bin_reg <= 0, err <= 1.
  - Otherwise: err <= 0 and normal conversion.
  - err is registered and changes only on start acceptance or reset.
- Undefined:
  - err is tied to 0.
  - Invalid digits are converted without checking; the result is unspecified but deterministic.
  - Latency is always BIN_W+1.

Decomposition:
- Shared package:
  - Default constants NDIG_DEF = 6 and BIN_W_DEF = 20.
  - FSM state encoding: idle = 2'd0, op = 2'd1, done = 2'd2, reused consistently with the other iterative blocks.
- One natural sub-module: bcd_digit_adj.
  - Purely combinational, 4-bit in and 4-bit out.
  - Output = in - 3 if in >= 8, else in.
  - Instantiated NDIG times with a generate loop.

Test Plan:
- bcd = 24'h999999, pulse start -> done_tick exactly 21 cycles later, bin = 20'hF423F (999999), err = 0.
- bcd = 24'h000000 -> bin = 0. Then bcd = 24'h000063 -> bin = 63 (20'h0003F). Then bcd = 24'h123456 -> bin = 20'h1E240.
- Start 24'h000100, re-pulse start with bcd = 24'h999999 mid-op, and change bcd during op -> single done_tick, bin = 100, ready low throughout.
- start held high with alternating 24'h000001 / 24'h000010 -> done_tick every 22 cycles, bin = 1 then 10; ready high exactly one cycle between conversions.
- Assert rst_n = 0 at cycle 10 of a conversion -> immediate ready = 1, bin = 0, no done_tick. A new start after release converts correctly.
- With BCD2BIN_CHECK_EN defined, bcd = 24'h00000A -> done_tick 1 cycle after start, err = 1, bin = 0. A following bcd = 24'h000009 -> err = 0, bin = 9.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared constants and FSM encoding for the bcd2bin converter.
// Optional input-digit checking is enabled with BCD2BIN_CHECK_EN.
package bcd2bin_pkg;

    localparam int NDIG_DEF  = 6;
    localparam int BIN_W_DEF = 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// start/ready/done_tick handshake bundle for bcd2bin.
// The master drives start and bcd; the slave returns the result.
interface bcd2bin_if
    import bcd2bin_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int BIN_W = BIN_W_DEF
);

    logic              start;
    logic [4*NDIG-1:0] bcd;
    logic              ready;
    logic              done_tick;
    logic [BIN_W-1:0]  bin;
    logic              err;

    modport master (
        output start, bcd,
        input  ready, done_tick, bin, err
    );

    modport slave (
        input  start, bcd,
        output ready, done_tick, bin, err
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble:
// a shifted digit of 8 or more gets 3 subtracted.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = din[3] ? din - 4'd3 : din;

endmodule

// File: rtl/bcd2bin.sv
// Iterative BCD-to-binary converter (reverse double-dabble).
// Define BCD2BIN_CHECK_EN to reject inputs with digits above 9.
module bcd2bin
    import bcd2bin_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int BIN_W = BIN_W_DEF
) (
    input logic       clk,
    input logic       rst_n,
    bcd2bin_if.slave  bus
);

    localparam int CW = $clog2(BIN_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);

    state_t            state;
    state_t            state_nx;
    logic [4*NDIG-1:0] bcd_reg;
    logic [4*NDIG-1:0] bcd_sh;
    logic [4*NDIG-1:0] bcd_adj;
    logic [BIN_W-1:0]  bin_reg;
    logic [BIN_W-1:0]  bin_sh;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              bad;

    assign accept = (state == S_IDLE) && bus.start;

    // bcd_reg LSB falls into the binary MSB on each step
    assign bcd_sh = bcd_reg >> 1;
    assign bin_sh = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_sh[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    logic err_reg;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digit_bad(bus.bcd[4*i +: 4])) bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= bad;
        end
    end

    assign bus.err = err_reg;
`else
    assign bad     = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start) state_nx = bad ? S_DONE : S_OP;
            end
            S_OP: begin
                if (cnt == '0) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready     = (state == S_IDLE);
        bus.done_tick = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
        end else if (accept) begin
            bcd_reg <= bus.bcd;
            bin_reg <= '0;
            cnt     <= CNT_LAST;
        end else if (state == S_OP) begin
            bcd_reg <= bcd_adj;
            bin_reg <= bin_sh;
            if (cnt != '0) cnt <= cnt - CW'(1);
        end
    end

    assign bus.bin = bin_reg;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: vector table, random
// conversions against a decimal model, handshake corner cases.
module tb_bcd2bin;
    import bcd2bin_pkg::*;

    localparam int NDIG  = 6;
    localparam int BIN_W = 20;
    localparam int LAT   = BIN_W + 1;

    typedef struct {
        logic [23:0] bcd;
        logic [19:0] bin;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd2bin_if #(.NDIG(NDIG), .BIN_W(BIN_W)) bus ();

    bcd2bin #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Decimal value of the packed digits, by plain arithmetic
    function automatic logic [19:0] ref_bin(input logic [23:0] b);
        int v;
        v = 0;
        for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v[19:0];
    endfunction

    function automatic logic [23:0] rand_bcd();
        logic [23:0] b;
        for (int i = 0; i < NDIG; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

    // Called while idle; ends at the idle cycle after done
    task automatic do_conv(input string nm, input logic [23:0] b,
                           input int exp_lat, input logic [19:0] exp_bin,
                           input logic exp_err);
        int n;
        int rdy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bcd   = 24'($urandom);
        n   = 1;
        rdy = 0;
        while (n < 100 && !bus.done_tick) begin
            if (bus.ready) rdy++;
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n, exp_lat);
        check({nm, " bin"}, 32'(bus.bin), 32'(exp_bin));
        check({nm, " err"}, 32'(bus.err), 32'(exp_err));
        check({nm, " ready_in_op"}, rdy, 0);
        @(negedge clk);
        check({nm, " done_one_cycle"}, 32'(bus.done_tick), 0);
        check({nm, " ready_after"}, 32'(bus.ready), 1);
    endtask

    initial begin
        vec_t vt[7];
        int   n;
        int   dcnt;
        int   dn;
        int   rdy;
        logic [19:0] db;
        logic [23:0] b;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bcd   = '0;

        vt[0] = '{24'h999999, 20'hF423F};
        vt[1] = '{24'h000000, 20'h00000};
        vt[2] = '{24'h000063, 20'h0003F};
        vt[3] = '{24'h123456, 20'h1E240};
        vt[4] = '{24'h000100, 20'h00064};
        vt[5] = '{24'h000010, 20'h0000A};
        vt[6] = '{24'h100000, 20'h186A0};

        #2;
        check("reset ready", 32'(bus.ready), 1);
        check("reset done", 32'(bus.done_tick), 0);
        check("reset bin", 32'(bus.bin), 0);
        check("reset err", 32'(bus.err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_conv($sformatf("vec%0d", i), vt[i].bcd, LAT, vt[i].bin, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            b = rand_bcd();
            do_conv($sformatf("rnd%0d", i), b, LAT, ref_bin(b), 1'b0);
        end

        // Restart attempt and bcd change while busy
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 24'h000100;
        dcnt = 0;
        dn   = 0;
        rdy  = 0;
        db   = '0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.start = (n == 5);
            if (n == 5) bus.bcd = 24'h999999;
            if (n == 6) bus.bcd = 24'h555555;
            if (bus.done_tick) begin
                dcnt++;
                if (dcnt == 1) begin
                    dn = n;
                    db = bus.bin;
                end
            end
            if (dcnt == 0 && bus.ready) rdy++;
        end
        check("restart done_count", dcnt, 1);
        check("restart latency", dn, LAT);
        check("restart bin", 32'(db), 100);
        check("restart ready_in_op", rdy, 0);

        // Start held high: back-to-back conversions
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 24'h000001;
        n = 0;
        while (n < 60 && !bus.done_tick) begin
            @(negedge clk);
            n++;
        end
        check("held first latency", n, LAT);
        check("held first bin", 32'(bus.bin), 1);
        bus.bcd = 24'h000010;
        n   = 0;
        rdy = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.ready) rdy++;
        end while (n < 60 && !bus.done_tick);
        check("held period", n, BIN_W + 2);
        check("held ready_cycles", rdy, 1);
        check("held second bin", 32'(bus.bin), 10);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-conversion
        bus.start = 1'b1;
        bus.bcd   = 24'h123456;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre-reset busy", 32'(bus.ready), 0);
        rst_n = 1'b0;
        #1;
        check("async rst ready", 32'(bus.ready), 1);
        check("async rst bin", 32'(bus.bin), 0);
        check("async rst done", 32'(bus.done_tick), 0);
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done_tick) dcnt++;
        end
        check("rst no done", dcnt, 0);
        rst_n = 1'b1;
        do_conv("post-reset", 24'h000063, LAT, 20'h0003F, 1'b0);

`ifdef BCD2BIN_CHECK_EN
        do_conv("bad digit", 24'h00000A, 1, 20'h0, 1'b1);
        do_conv("after bad", 24'h000009, LAT, 20'h9, 1'b0);
        for (int i = 0; i < 10; i++) begin
            b = rand_bcd();
            if (i[0]) b[4*(i % NDIG) +: 4] = 4'($urandom_range(10, 15));
            if (i[0]) do_conv($sformatf("chk%0d", i), b, 1, 20'h0, 1'b1);
            else do_conv($sformatf("chk%0d", i), b, LAT, ref_bin(b), 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
